input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 125 ++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//   Debounces a raw, bouncing pushbutton/switch input. A new level is
//   accepted only after DEBOUNCE_CNT consecutive clock edges on which the
//   sampled input disagrees with the current debounced level. Any agreeing
//   sample restarts the qualification. One-cycle rise/fall pulses are
//   generated on accepted changes, and accepted rising changes are counted.
//
// Configuration:
//   INPUT_COND_SYNC_EN - when defined, btn_in passes through a two-flop
//                        synchronizer before debouncing. When undefined,
//                        btn_in is assumed to be synchronous to clk already.
//
// Parameters:
//   DEBOUNCE_CNT - consecutive differing samples needed (1..2^CNT_W-1)
//   CNT_W        - debounce counter width
//   DEFAULT      - reset/idle level of the conditioned input
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   btn_in      in   raw bouncing input
//   btn_level   out  debounced level (registered)
//   btn_rise    out  one-cycle pulse on accepted 0->1 change (registered)
//   btn_fall    out  one-cycle pulse on accepted 1->0 change (registered)
//   press_count out  8-bit wrapping count of accepted rising changes
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int   DEBOUNCE_CNT = 4,
  parameter int   CNT_W        = 16,
  parameter logic DEFAULT      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_rise,
  output logic       btn_fall,
  output logic [7:0] press_count
);

  // Counter value on which the next differing sample completes qualification.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sampled;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic [7:0]       count_q, count_d;

`ifdef INPUT_COND_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= DEFAULT;
      sync2_q <= DEFAULT;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = btn_in;
`endif

  // Debounce qualification, edge pulse and press counter next-state logic.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    count_d = count_q;

    if (sampled == level_q) begin
      // Agreeing sample: any partial qualification is discarded.
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      // Final differing sample of the run: accept the new level.
      level_d = sampled;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Pulses are derived from the level transition taken on this edge, so
    // they appear in the same cycle the new level becomes visible.
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;

    if (rise_d) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State registers; reset overrides any qualification completing this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= DEFAULT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign press_count = count_q;

endmodule
